// File: rtl/reflet_interrupt_ctrl_if.sv
// CPU data-bus slice seen by the interrupt controller: address, write data/strobe,
// bus enable and the OR-able registered read data.
interface reflet_int_bus_if #(
    parameter int unsigned wordsize = 8
);
    logic                enable;
    logic [wordsize-1:0] addr;
    logic [wordsize-1:0] data_in;
    logic                write_en;
    logic [wordsize-1:0] data_out;

    modport master (
        output enable, addr, data_in, write_en,
        input  data_out
    );

    modport slave (
        input  enable, addr, data_in, write_en,
        output data_out
    );
endinterface

// File: rtl/reflet_interrupt_ctrl.sv
// Memory-mapped 4-line interrupt controller (PENDING/MASK/MODE/STATUS) for reflet_cpu.
// Define REFLET_INT_SYNC_EN to insert a 2-flop synchronizer on every irq_in line.
module reflet_interrupt_ctrl #(
    parameter int unsigned         wordsize  = 8,
    parameter logic [wordsize-1:0] base_addr = wordsize'('hF0)
) (
    input  logic                   clk,
    input  logic                   reset,
    reflet_int_bus_if.slave        bus,
    input  logic [3:0]             irq_in,
    output logic [3:0]             interrupt_request
);

    localparam int unsigned nlines = 4;
`ifdef REFLET_INT_SYNC_EN
    localparam int unsigned warm_len = 3;
`else
    localparam int unsigned warm_len = 1;
`endif

    logic [nlines-1:0]   s;
    logic [nlines-1:0]   prev;
    logic [warm_len-1:0] warm;
    logic                primed;
    logic [nlines-1:0]   pending, mask, mode;
    logic [nlines-1:0]   pending_next, mask_next, mode_next;
    logic [nlines-1:0]   clr, set, act;
    logic [1:0]          act_idx;
    logic [wordsize-1:0] offset, rd_data;
    logic [1:0]          reg_sel;
    logic [nlines-1:0]   wdata;
    logic                selected, wr_hit, rd_hit;

`ifdef REFLET_INT_SYNC_EN
    logic [nlines-1:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = irq_in;
`endif

    // Edge detect stays blind until prev holds a genuine post-reset sample.
    assign primed = warm[warm_len-1];

    assign offset   = bus.addr - base_addr;
    assign selected = (bus.addr >= base_addr) && (offset < wordsize'(4));
    assign wr_hit   = selected & bus.write_en & bus.enable;
    assign rd_hit   = selected & bus.enable & ~bus.write_en;
    assign reg_sel  = offset[1:0];
    assign wdata    = bus.data_in[nlines-1:0];

    assign act = pending & mask;
    assign set = (mode & s) | (~mode & s & ~prev & {nlines{primed}});

    always_comb begin
        clr       = '0;
        mask_next = mask;
        mode_next = mode;
        if (wr_hit) begin
            case (reg_sel)
                2'd0:    clr       = wdata;
                2'd1:    mask_next = wdata;
                2'd2:    mode_next = wdata;
                default: ;
            endcase
        end
        // Set after clear so a request arriving with its own W1C is kept.
        pending_next = (pending & ~clr) | set;
    end

    always_comb begin
        act_idx = 2'd0;
        for (int i = nlines - 1; i >= 0; i--) begin
            if (act[i]) act_idx = 2'(i);
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0: rd_data[nlines-1:0] = pending;
            2'd1: rd_data[nlines-1:0] = mask;
            2'd2: rd_data[nlines-1:0] = mode;
            default: begin
                rd_data[7]   = |act;
                rd_data[1:0] = act_idx;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev              <= '0;
            warm              <= '0;
            pending           <= '0;
            mask              <= '0;
            mode              <= '0;
            interrupt_request <= '0;
            bus.data_out      <= '0;
        end else begin
            prev              <= s;
            warm              <= warm_len'({warm, 1'b1});
            pending           <= pending_next;
            mask              <= mask_next;
            mode              <= mode_next;
            interrupt_request <= pending_next & mask_next;
            bus.data_out      <= rd_hit ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_reflet_interrupt_ctrl.sv
// Scoreboard bench for reflet_interrupt_ctrl: stimulus queues expected read data and
// request vectors, a monitor pops and compares them one edge later.
module tb_reflet_interrupt_ctrl;

`ifdef REFLET_INT_SYNC_EN
    localparam int sync_lat = 2;
`else
    localparam int sync_lat = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq_in = 4'h0;
    logic [3:0] interrupt_request;

    reflet_int_bus_if #(.wordsize(8)) bus ();

    reflet_interrupt_ctrl #(.wordsize(8), .base_addr(8'hF0)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus.slave),
        .irq_in            (irq_in),
        .interrupt_request (interrupt_request)
    );

    always #5 clk = ~clk;

    logic [7:0] rd_q[$];
    string      rd_nm[$];
    logic [3:0] irq_q[$];
    string      irq_nm[$];
    logic       chk_rd = 1'b0;
    logic       chk_irq = 1'b0;
    int         errors = 0;
    int         checks = 0;

    // Monitor: compares whatever the stimulus flagged for the edge just taken.
    initial begin
        logic       k_rd, k_irq;
        logic [7:0] e8;
        logic [3:0] e4;
        string      n;
        forever begin
            @(posedge clk);
            k_rd  = chk_rd;
            k_irq = chk_irq;
            #1;
            if (k_rd) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_queue_empty: no expected read data queued");
                end else begin
                    e8 = rd_q.pop_front();
                    n  = rd_nm.pop_front();
                    if (bus.data_out !== e8) begin
                        errors++;
                        $display("FAIL %s: data_out=%h expected %h", n, bus.data_out, e8);
                    end
                end
            end
            if (k_irq) begin
                checks++;
                if (irq_q.size() == 0) begin
                    errors++;
                    $display("FAIL irq_queue_empty: no expected request queued");
                end else begin
                    e4 = irq_q.pop_front();
                    n  = irq_nm.pop_front();
                    if (interrupt_request !== e4) begin
                        errors++;
                        $display("FAIL %s: interrupt_request=%b expected %b", n, interrupt_request, e4);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
        bus.enable   = 1'b1;
        bus.write_en = 1'b0;
        bus.addr     = 8'h00;
        bus.data_in  = 8'h00;
        chk_rd       = 1'b0;
        chk_irq      = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc();
        bus.addr     = a;
        bus.data_in  = d;
        bus.write_en = 1'b1;
    endtask

    task automatic push_rd(input string name, input logic [7:0] e);
        rd_q.push_back(e);
        rd_nm.push_back(name);
        chk_rd = 1'b1;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [7:0] e);
        cyc();
        bus.addr = a;
        push_rd(name, e);
    endtask

    task automatic exp_irq(input string name, input logic [3:0] e);
        irq_q.push_back(e);
        irq_nm.push_back(name);
        chk_irq = 1'b1;
    endtask

    initial begin
        bus.enable   = 1'b1;
        bus.write_en = 1'b0;
        bus.addr     = 8'h00;
        bus.data_in  = 8'h00;

        // reset and register reset values
        repeat (4) cyc();
        cyc(); reset = 1'b0; exp_irq("rst_irq", 4'h0);
        rd("rst_pending", 8'hF0, 8'h00);
        rd("rst_mask",    8'hF1, 8'h00);
        rd("rst_mode",    8'hF2, 8'h00);
        rd("rst_status",  8'hF3, 8'h00);

        // edge pulse on line 0, status, W1C
        wr(8'hF1, 8'h01);
        cyc(); irq_in[0] = 1'b1;
        cyc(); irq_in[0] = 1'b0;
        repeat (sync_lat) cyc();
        cyc(); exp_irq("irq0_raised", 4'h1);
        rd("status_line0", 8'hF3, 8'h80);
        wr(8'hF0, 8'h01); exp_irq("irq0_w1c_drop", 4'h0);
        rd("pending_after_w1c", 8'hF0, 8'h00);

        // masked line latches, unmask raises request
        wr(8'hF1, 8'h00);
        cyc(); irq_in[2] = 1'b1;
        cyc(); irq_in[2] = 1'b0;
        repeat (sync_lat) cyc();
        cyc(); exp_irq("masked_no_irq", 4'h0);
        rd("masked_pending", 8'hF0, 8'h04);
        wr(8'hF1, 8'h04); exp_irq("unmask_raises", 4'h4);
        rd("status_line2", 8'hF3, 8'h82);
        wr(8'hF0, 8'h04); exp_irq("line2_cleared", 4'h0);

        // level mode on line 1
        wr(8'hF2, 8'h02);
        wr(8'hF1, 8'h02);
        cyc(); irq_in[1] = 1'b1;
        repeat (sync_lat) cyc();
        cyc(); exp_irq("lvl_irq", 4'h2);
        wr(8'hF0, 8'h02); exp_irq("lvl_w1c_held", 4'h2);
        rd("lvl_pending_held", 8'hF0, 8'h02);
        cyc(); irq_in[1] = 1'b0;
        repeat (sync_lat + 1) cyc();
        wr(8'hF0, 8'h02); exp_irq("lvl_cleared", 4'h0);
        rd("lvl_pending_clr", 8'hF0, 8'h00);

        // edge and W1C of the same bit in one cycle
        cyc(); irq_in[0] = 1'b1;
        cyc(); irq_in[0] = 1'b0;
        repeat (sync_lat) cyc();
        for (int i = 0; i <= sync_lat; i++) begin
            if (i == sync_lat) wr(8'hF0, 8'h01);
            else cyc();
            if (i == 0) irq_in[0] = 1'b1;
        end
        cyc(); irq_in[0] = 1'b0;
        rd("set_wins_w1c", 8'hF0, 8'h01);
        repeat (sync_lat) cyc();
        wr(8'hF0, 8'h01);

        // bus disabled: writes ignored, capture continues, data_out zero
        wr(8'hF1, 8'h01);
        cyc(); bus.enable = 1'b0; irq_in[0] = 1'b1;
        cyc(); bus.enable = 1'b0; irq_in[0] = 1'b0;
        bus.addr = 8'hF1; bus.data_in = 8'h00; bus.write_en = 1'b1;
        repeat (sync_lat) begin cyc(); bus.enable = 1'b0; end
        cyc(); bus.enable = 1'b0; bus.addr = 8'hF0;
        push_rd("rd_while_disabled", 8'h00);
        exp_irq("irq_while_disabled", 4'h1);
        rd("mask_write_ignored", 8'hF1, 8'h01);
        rd("pending_while_disabled", 8'hF0, 8'h01);
        rd("rd_below_range", 8'hEF, 8'h00);
        rd("rd_above_range", 8'hF4, 8'h00);
        wr(8'hF0, 8'h01); exp_irq("disabled_line_cleared", 4'h0);

        // out-of-range and STATUS writes, upper data bits
        wr(8'hF5, 8'h0F);
        wr(8'hF3, 8'hFF);
        rd("mask_after_oob", 8'hF1, 8'h01);
        rd("mode_after_oob", 8'hF2, 8'h02);
        wr(8'hF1, 8'hF3);
        rd("upper_bits_ignored", 8'hF1, 8'h03);

        // line held high across reset release is not an edge
        wr(8'hF2, 8'h00);
        cyc(); irq_in[3] = 1'b1; reset = 1'b1;
        repeat (3) cyc();
        cyc(); reset = 1'b0; exp_irq("rst_mid_irq", 4'h0);
        rd("mask_cleared_by_reset", 8'hF1, 8'h00);
        repeat (3) cyc();
        wr(8'hF1, 8'h08);
        repeat (sync_lat + 2) cyc();
        rd("held_high_no_edge", 8'hF0, 8'h00); exp_irq("held_high_no_irq", 4'h0);
        cyc(); irq_in[3] = 1'b0;
        repeat (sync_lat + 1) cyc();
        cyc(); irq_in[3] = 1'b1;
        repeat (sync_lat) cyc();
        cyc(); exp_irq("irq3_edge", 4'h8);
        rd("status_line3", 8'hF3, 8'h83);

        cyc();
        cyc();
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: rd=%0d irq=%0d expected 0", rd_q.size(), irq_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
